step_response_meas: RTL and testbench

Parametrised step-response harness for fixed-point emulated analog blocks. It drives a programmable sequence of DC step levels onto a shared stimulus bus feeding up to N_CH filter instances, then measures settling per channel against a tolerance band. It sits in the emulation testbench between the stimulus constants and the `PROBE_ANALOG` outputs, and replaces one-off constant-input benches with a self-checking multi-step, multi-channel measurement.

---
 rtl/step_response_meas.sv | 241 ++++++++++++++++++++++++
 tb/tb_step_response_meas.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_response_meas.sv
// -----------------------------------------------------------------------------
// step_response_meas
//
// Step-response harness for fixed-point emulated analog blocks. A sequence of
// STEPS DC levels is driven onto a shared stimulus bus (v_in). Each level is
// held for D = max(dwell,1) cycles. Every cycle, each channel's filter output
// is compared against the stimulus, and per-step settling results are
// reported with a one-cycle res_valid pulse.
//
// Optional feature macro: STEP_MEAS_PEAK_EN
//   defined   : peak_err reports the max |v_out - v_in| seen during the step
//   undefined : peak tracking is not built and peak_err is tied to zero
//
// Ports
//   clk        emulation clock
//   rst        synchronous active-high reset
//   start      begin a sequence (only honoured while idle)
//   levels     step level k at [k*WIDTH +: WIDTH], signed
//   dwell      cycles per step (0 behaves as 1)
//   v_in       registered stimulus to all filters
//   v_out      filter outputs, channel c at [c*WIDTH +: WIDTH]
//   busy       high while a sequence is being driven
//   res_valid  one-cycle pulse per completed step
//   res_step   index of the reported step
//   settle_cnt per-channel settle time (cycles) of the reported step
//   settled    per-channel: final sample of the step was within tolerance
//   peak_err   per-channel max |error| of the reported step (WIDTH+1 bits)
//   done       one-cycle pulse coinciding with the final res_valid
// -----------------------------------------------------------------------------
module step_response_meas #(
    parameter int N_CH    = 2,
    parameter int WIDTH   = 18,
    parameter int EXP     = -12,
    parameter int STEPS   = 4,
    parameter int DWELL_W = 16,
    parameter int TOL     = 41
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [STEPS*WIDTH-1:0]                        levels,
    input  logic [DWELL_W-1:0]                            dwell,
    output logic [WIDTH-1:0]                              v_in,
    input  logic [N_CH*WIDTH-1:0]                         v_out,
    output logic                                          busy,
    output logic                                          res_valid,
    output logic [((STEPS > 1) ? $clog2(STEPS) : 1)-1:0]  res_step,
    output logic [N_CH*DWELL_W-1:0]                       settle_cnt,
    output logic [N_CH-1:0]                               settled,
    output logic [N_CH*(WIDTH+1)-1:0]                     peak_err,
    output logic                                          done
);

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int EW = WIDTH + 1;
    localparam logic [EW-1:0] TOL_E = EW'(TOL);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    // |a - b| evaluated one bit wider than the operands so it cannot overflow.
    function automatic logic [EW-1:0] abs_err(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [EW-1:0] diff;
        diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (diff[EW-1]) begin
            return (~diff) + EW'(1);
        end else begin
            return diff;
        end
    endfunction

    logic [0:0]          state_r;
    logic [SW-1:0]       step_idx_r;
    logic [DWELL_W-1:0]  dwell_cnt_r;
    logic [WIDTH-1:0]    v_in_r;
    logic                busy_r;
    logic                res_valid_r;
    logic                done_r;
    logic [SW-1:0]       res_step_r;
    logic [N_CH*DWELL_W-1:0] settle_cnt_r;
    logic [N_CH-1:0]     settled_r;
    logic [DWELL_W-1:0]  last_bad_r [N_CH];

    logic [DWELL_W-1:0]  dwell_eff_s;
    logic                last_s;
    logic                step_last_s;
    logic [SW-1:0]       step_nxt_s;
    logic [EW-1:0]       abs_s [N_CH];
    logic [N_CH-1:0]     bad_s;
    logic [DWELL_W-1:0]  last_bad_nxt_s [N_CH];

    // Effective dwell: a programmed dwell of 0 is treated as a single cycle.
    always_comb begin
        if (dwell == {DWELL_W{1'b0}}) begin
            dwell_eff_s = DWELL_W'(1);
        end else begin
            dwell_eff_s = dwell;
        end
    end

    assign last_s      = (dwell_cnt_r == (dwell_eff_s - DWELL_W'(1)));
    assign step_last_s = (step_idx_r == SW'(STEPS - 1));
    assign step_nxt_s  = step_idx_r + SW'(1);

    // Per-channel error magnitude, band check and running last-bad index.
    // last_bad_nxt includes the current sample so the final sample of the
    // step can report D when the channel is still out of band.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            abs_s[c] = abs_err(v_out[c*WIDTH +: WIDTH], v_in_r);
            bad_s[c] = (abs_s[c] > TOL_E);
            if (bad_s[c]) begin
                last_bad_nxt_s[c] = dwell_cnt_r + DWELL_W'(1);
            end else begin
                last_bad_nxt_s[c] = last_bad_r[c];
            end
        end
    end

    // Sequencer FSM, stimulus register and per-step result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            step_idx_r   <= {SW{1'b0}};
            dwell_cnt_r  <= {DWELL_W{1'b0}};
            v_in_r       <= {WIDTH{1'b0}};
            busy_r       <= 1'b0;
            res_valid_r  <= 1'b0;
            done_r       <= 1'b0;
            res_step_r   <= {SW{1'b0}};
            settle_cnt_r <= {(N_CH*DWELL_W){1'b0}};
            settled_r    <= {N_CH{1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                last_bad_r[c] <= {DWELL_W{1'b0}};
            end
        end else begin
            res_valid_r <= 1'b0;
            done_r      <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    for (int c = 0; c < N_CH; c++) begin
                        last_bad_r[c] <= {DWELL_W{1'b0}};
                    end
                    if (start) begin
                        state_r     <= S_DRIVE;
                        busy_r      <= 1'b1;
                        step_idx_r  <= {SW{1'b0}};
                        dwell_cnt_r <= {DWELL_W{1'b0}};
                        v_in_r      <= levels[WIDTH-1:0];
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (last_s) begin
                        res_valid_r <= 1'b1;
                        res_step_r  <= step_idx_r;
                        for (int c = 0; c < N_CH; c++) begin
                            settle_cnt_r[c*DWELL_W +: DWELL_W] <= last_bad_nxt_s[c];
                            settled_r[c]  <= ~bad_s[c];
                            last_bad_r[c] <= {DWELL_W{1'b0}};
                        end
                        dwell_cnt_r <= {DWELL_W{1'b0}};
                        if (step_last_s) begin
                            // v_in keeps the last level after the sequence.
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            step_idx_r <= step_nxt_s;
                            v_in_r     <= levels[int'(step_nxt_s)*WIDTH +: WIDTH];
                        end
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r + DWELL_W'(1);
                        for (int c = 0; c < N_CH; c++) begin
                            last_bad_r[c] <= last_bad_nxt_s[c];
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_MEAS_PEAK_EN
    logic [EW-1:0]        peak_r     [N_CH];
    logic [EW-1:0]        peak_nxt_s [N_CH];
    logic [N_CH*EW-1:0]   peak_err_r;

    // Running maximum of |error| including the current sample.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            if (abs_s[c] > peak_r[c]) begin
                peak_nxt_s[c] = abs_s[c];
            end else begin
                peak_nxt_s[c] = peak_r[c];
            end
        end
    end

    // Peak accumulators: cleared while idle and at each step boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_err_r <= {(N_CH*EW){1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                peak_r[c] <= {EW{1'b0}};
            end
        end else if (state_r == S_DRIVE) begin
            for (int c = 0; c < N_CH; c++) begin
                if (last_s) begin
                    peak_err_r[c*EW +: EW] <= peak_nxt_s[c];
                    peak_r[c]              <= {EW{1'b0}};
                end else begin
                    peak_r[c] <= peak_nxt_s[c];
                end
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                peak_r[c] <= {EW{1'b0}};
            end
        end
    end

    assign peak_err = peak_err_r;
`else
    assign peak_err = {(N_CH*EW){1'b0}};
`endif

    assign v_in       = v_in_r;
    assign busy       = busy_r;
    assign res_valid  = res_valid_r;
    assign res_step   = res_step_r;
    assign settle_cnt = settle_cnt_r;
    assign settled    = settled_r;
    assign done       = done_r;

endmodule

// File: tb/tb_step_response_meas.sv
module tb_step_response_meas;

    localparam int N_CH    = 2;
    localparam int WIDTH   = 18;
    localparam int STEPS   = 4;
    localparam int DWELL_W = 16;
    localparam int TOL     = 41;
    localparam int EW      = WIDTH + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [STEPS*WIDTH-1:0]  levels;
    logic [DWELL_W-1:0]      dwell;
    logic [WIDTH-1:0]        v_in;
    logic [N_CH*WIDTH-1:0]   v_out;
    logic                    busy;
    logic                    res_valid;
    logic [1:0]              res_step;
    logic [N_CH*DWELL_W-1:0] settle_cnt;
    logic [N_CH-1:0]         settled;
    logic [N_CH*EW-1:0]      peak_err;
    logic                    done;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // per-channel source: 0 = loopback (v_in delayed 1 cycle), 1 = constant
    logic [N_CH-1:0]   mode;
    logic [WIDTH-1:0]  cval [N_CH];
    logic [WIDTH-1:0]  lb = '0;

    typedef struct packed {
        logic [1:0]  step;
        int          cyc;
        logic [31:0] settle;
        logic [1:0]  settled;
        logic [37:0] peak;
        logic        done;
    } exp_t;

    exp_t q[$];
    exp_t e;

    step_response_meas #(
        .N_CH(N_CH), .WIDTH(WIDTH), .EXP(-12), .STEPS(STEPS),
        .DWELL_W(DWELL_W), .TOL(TOL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .levels(levels), .dwell(dwell),
        .v_in(v_in), .v_out(v_out), .busy(busy), .res_valid(res_valid),
        .res_step(res_step), .settle_cnt(settle_cnt), .settled(settled),
        .peak_err(peak_err), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) lb <= v_in;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            v_out[c*WIDTH +: WIDTH] = mode[c] ? cval[c] : lb;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input int step, input int cy, input int s0, input int s1,
                                input bit st0, input bit st1, input int p0, input int p1,
                                input bit dn);
        exp_t r;
        r.step    = step[1:0];
        r.cyc     = cy;
        r.settle  = {s1[15:0], s0[15:0]};
        r.settled = {st1, st0};
`ifdef STEP_MEAS_PEAK_EN
        r.peak    = {p1[18:0], p0[18:0]};
`else
        r.peak    = 38'd0;
`endif
        r.done    = dn;
        return r;
    endfunction

    // Monitor: pops one expectation per res_valid and compares all results.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (res_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_res_valid", 64'(res_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("res_step",   64'(res_step),   64'(e.step));
                    chk("res_cycle",  64'(cyc),        64'(e.cyc));
                    chk("settle_cnt", 64'(settle_cnt), 64'(e.settle));
                    chk("settled",    64'(settled),    64'(e.settled));
                    chk("peak_err",   64'(peak_err),   64'(e.peak));
                    chk("done",       64'(done),       64'(e.done));
                    if (e.done) chk("busy_at_done", 64'(busy), 64'd0);
                end
            end else if (done !== 1'b0) begin
                chk("stray_done", 64'(done), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start(output int es);
        start = 1'b1;
        tick();
        es = cyc;
        start = 1'b0;
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(q.size()), 64'd0);
    endtask

    task automatic set_levels(input int a, input int b, input int c, input int d);
        logic [WIDTH-1:0] la, lbv, lc, ld;
        la = a[WIDTH-1:0]; lbv = b[WIDTH-1:0]; lc = c[WIDTH-1:0]; ld = d[WIDTH-1:0];
        levels = {ld, lc, lbv, la};
    endtask

    task automatic push_loopback(input int es);
        int pk [4] = '{4096, 4096, 4096, 6144};
        for (int j = 0; j < 4; j++) begin
            q.push_back(mk(j, es + 8*(j+1), 1, 1, 1'b1, 1'b1, pk[j], pk[j], j == 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int es;
        int es2;
        int pk [4] = '{4096, 4096, 4096, 6144};
        rst = 1'b1; start = 1'b0; dwell = '0; levels = '0;
        mode = 2'b00; cval[0] = '0; cval[1] = '0;

        // reset state
        tick(); tick();
        chk("rst_v_in",       64'(v_in),       64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_res_valid",  64'(res_valid),  64'd0);
        chk("rst_done",       64'(done),       64'd0);
        chk("rst_res_step",   64'(res_step),   64'd0);
        chk("rst_settle_cnt", 64'(settle_cnt), 64'd0);
        chk("rst_settled",    64'(settled),    64'd0);
        chk("rst_peak_err",   64'(peak_err),   64'd0);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_v_in", 64'(v_in), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // loopback on both channels, dwell 8
        set_levels(4096, 0, -4096, 2048);
        dwell = 16'd8;
        pulse_start(es);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_v_in", 64'(v_in), 64'(18'd4096));
        push_loopback(es);
        wait_empty(60, "loopback_drain");
        chk("loopback_idle_busy", 64'(busy), 64'd0);
        chk("loopback_hold_v_in", 64'(v_in), 64'(18'd2048));

        // stuck output: both channels at 0, level 4096, dwell 10
        do_reset();
        mode = 2'b11; cval[0] = '0; cval[1] = '0;
        set_levels(4096, 4096, 4096, 4096);
        dwell = 16'd10;
        pulse_start(es);
        for (int j = 0; j < 4; j++)
            q.push_back(mk(j, es + 10*(j+1), 10, 10, 1'b0, 1'b0, 4096, 4096, j == 3));
        wait_empty(60, "stuck_drain");

        // band edge: ch1 exactly TOL away (in band)
        do_reset();
        mode = 2'b10; cval[1] = 18'd4137;
        dwell = 16'd8;
        pulse_start(es);
        q.push_back(mk(0, es + 8, 1, 0, 1'b1, 1'b1, 4096, 41, 1'b0));
        for (int j = 1; j < 4; j++)
            q.push_back(mk(j, es + 8*(j+1), 0, 0, 1'b1, 1'b1, 0, 41, j == 3));
        wait_empty(60, "band_in_drain");

        // band edge: ch1 TOL+1 away (out of band for the whole step)
        do_reset();
        cval[1] = 18'd4138;
        pulse_start(es);
        q.push_back(mk(0, es + 8, 1, 8, 1'b1, 1'b0, 4096, 42, 1'b0));
        for (int j = 1; j < 4; j++)
            q.push_back(mk(j, es + 8*(j+1), 0, 8, 1'b1, 1'b0, 0, 42, j == 3));
        wait_empty(60, "band_out_drain");

        // reset during step 2 aborts the run without a result
        do_reset();
        mode = 2'b00;
        set_levels(4096, 0, -4096, 2048);
        pulse_start(es);
        for (int j = 0; j < 2; j++)
            q.push_back(mk(j, es + 8*(j+1), 1, 1, 1'b1, 1'b1, pk[j], pk[j], 1'b0));
        repeat (19) tick();
        chk("midreset_results_so_far", 64'(q.size()), 64'd0);
        rst = 1'b1;
        tick();
        chk("midreset_v_in",      64'(v_in),       64'd0);
        chk("midreset_busy",      64'(busy),       64'd0);
        chk("midreset_res_valid", 64'(res_valid),  64'd0);
        chk("midreset_done",      64'(done),       64'd0);
        chk("midreset_settle",    64'(settle_cnt), 64'd0);
        rst = 1'b0;
        repeat (30) tick();
        chk("midreset_quiet_busy", 64'(busy), 64'd0);
        pulse_start(es);
        push_loopback(es);
        wait_empty(60, "restart_drain");

        // dwell 0 behaves as 1, then restart in the done cycle
        do_reset();
        dwell = 16'd0;
        pulse_start(es);
        for (int j = 0; j < 4; j++)
            q.push_back(mk(j, es + j + 1, 1, 1, 1'b0, 1'b0, pk[j], pk[j], j == 3));
        begin
            int n = 0;
            while (done !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
        end
        chk("dwell0_done_seen",  64'(done), 64'd1);
        chk("dwell0_done_cycle", 64'(cyc),  64'(es + 4));
        es2 = cyc + 1;
        q.push_back(mk(0, es2 + 1, 1, 1, 1'b0, 1'b0, 2048, 2048, 1'b0));
        for (int j = 1; j < 4; j++)
            q.push_back(mk(j, es2 + j + 1, 1, 1, 1'b0, 1'b0, pk[j], pk[j], j == 3));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_restart_busy", 64'(busy), 64'd1);
        chk("done_restart_v_in", 64'(v_in), 64'(18'd4096));
        wait_empty(20, "dwell0_restart_drain");
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
